// File: rtl/alu_seq_muldiv.sv
// Sequential RV32I/RV32M ALU. Basic ops and divide special cases take 1 cycle; MUL/DIV iterate WIDTH cycles.
// IN_READY only in IDLE/DONE, so requests are ignored while iterating; KILL abandons work, RESET overrides all.
module alu_seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  localparam int SH_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SEL_W-1:0] SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             KILL,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY
);

  localparam logic [SEL_W-1:0] OP_AND    = SEL_W'('h00);
  localparam logic [SEL_W-1:0] OP_OR     = SEL_W'('h01);
  localparam logic [SEL_W-1:0] OP_ADD    = SEL_W'('h02);
  localparam logic [SEL_W-1:0] OP_XOR    = SEL_W'('h03);
  localparam logic [SEL_W-1:0] OP_SLL    = SEL_W'('h04);
  localparam logic [SEL_W-1:0] OP_SRL    = SEL_W'('h05);
  localparam logic [SEL_W-1:0] OP_SUB    = SEL_W'('h06);
  localparam logic [SEL_W-1:0] OP_SRA    = SEL_W'('h07);
  localparam logic [SEL_W-1:0] OP_SLT    = SEL_W'('h08);
  localparam logic [SEL_W-1:0] OP_SLTU   = SEL_W'('h09);
  localparam logic [SEL_W-1:0] OP_MUL    = SEL_W'('h10);
  localparam logic [SEL_W-1:0] OP_MULH   = SEL_W'('h11);
  localparam logic [SEL_W-1:0] OP_MULHSU = SEL_W'('h12);
  localparam logic [SEL_W-1:0] OP_MULHU  = SEL_W'('h13);
  localparam logic [SEL_W-1:0] OP_DIV    = SEL_W'('h14);
  localparam logic [SEL_W-1:0] OP_DIVU   = SEL_W'('h15);
  localparam logic [SEL_W-1:0] OP_REM    = SEL_W'('h16);
  localparam logic [SEL_W-1:0] OP_REMU   = SEL_W'('h17);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic [SEL_W-1:0]     op;
  logic                 neg_q, neg_r;
  logic [WIDTH-1:0]     result_q;
  logic                 zero_q;

  logic                 xfer;
  logic                 is_mul, is_div, is_divq, div_zero, div_ovf;
  logic                 go_mul, go_div;
  logic                 sgn_a, sgn_b, a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b, imm_res;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   step_nxt, prod_s;
  logic [WIDTH-1:0]     quo, rem, fin_res;

  assign xfer = IN_VALID & IN_READY;

  // Operand classification and sign/magnitude preparation at issue time.
  always_comb begin
    is_mul   = (SELECT == OP_MUL) || (SELECT == OP_MULH) ||
               (SELECT == OP_MULHSU) || (SELECT == OP_MULHU);
    is_divq  = (SELECT == OP_DIV) || (SELECT == OP_DIVU);
    is_div   = is_divq || (SELECT == OP_REM) || (SELECT == OP_REMU);
    sgn_a    = (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
               (SELECT == OP_DIV) || (SELECT == OP_REM);
    sgn_b    = (SELECT == OP_MULH) || (SELECT == OP_DIV) || (SELECT == OP_REM);
    a_neg    = sgn_a & DATA1[WIDTH-1];
    b_neg    = sgn_b & DATA2[WIDTH-1];
    mag_a    = a_neg ? -DATA1 : DATA1;
    mag_b    = b_neg ? -DATA2 : DATA2;
    div_zero = (DATA2 == '0);
    div_ovf  = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
               (DATA1 == MIN_NEG) && (DATA2 == '1);
    go_mul   = is_mul;
    go_div   = is_div && !div_zero && !div_ovf;
  end

  // Single-cycle results, including the divide special cases.
  always_comb begin
    imm_res = '0;
    case (SELECT)
      OP_AND:  imm_res = DATA1 & DATA2;
      OP_OR:   imm_res = DATA1 | DATA2;
      OP_ADD:  imm_res = DATA1 + DATA2;
      OP_XOR:  imm_res = DATA1 ^ DATA2;
      OP_SLL:  imm_res = DATA1 << DATA2[SH_W-1:0];
      OP_SRL:  imm_res = DATA1 >> DATA2[SH_W-1:0];
      OP_SUB:  imm_res = DATA1 - DATA2;
      OP_SRA:  imm_res = $signed(DATA1) >>> DATA2[SH_W-1:0];
      OP_SLT:  imm_res = {{(WIDTH-1){1'b0}}, $signed(DATA1) < $signed(DATA2)};
      OP_SLTU: imm_res = {{(WIDTH-1){1'b0}}, DATA1 < DATA2};
      OP_DIV, OP_DIVU: imm_res = div_zero ? '1 : MIN_NEG;
      OP_REM, OP_REMU: imm_res = div_zero ? DATA1 : '0;
      default: imm_res = '0;
    endcase
  end

  // One shift-add or restoring-subtract step; acc holds {high/rem, low/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (state == MUL)
      step_nxt = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      step_nxt = {acc[2*WIDTH-2:0], 1'b0};
    else
      step_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_comb begin
    prod_s = neg_q ? -step_nxt : step_nxt;
    quo    = neg_q ? -step_nxt[WIDTH-1:0] : step_nxt[WIDTH-1:0];
    rem    = neg_r ? -step_nxt[2*WIDTH-1:WIDTH] : step_nxt[2*WIDTH-1:WIDTH];
    case (op)
      OP_MUL:                        fin_res = prod_s[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_s[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fin_res = quo;
      default:                       fin_res = rem;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (KILL) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (xfer)             state_nxt = go_mul ? MUL : (go_div ? DIV : DONE);
          else                  state_nxt = IDLE;
        end
        MUL, DIV: if (cnt == '0) state_nxt = DONE;
        default:                state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    IN_READY  = (state == IDLE) || (state == DONE);
    BUSY      = (state == MUL) || (state == DIV);
    OUT_VALID = (state == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (!KILL) begin
      if (xfer) begin
        if (go_mul || go_div) begin
          op    <= SELECT;
          opnd  <= mag_b;
          acc   <= {{WIDTH{1'b0}}, mag_a};
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= WIDTH'(WIDTH-1);
        end else begin
          result_q <= imm_res;
          zero_q   <= (imm_res == '0);
        end
      end else if (BUSY) begin
        acc <= step_nxt;
        if (cnt == '0) begin
          result_q <= fin_res;
          zero_q   <= (fin_res == '0);
        end else begin
          cnt <= cnt - WIDTH'(1);
        end
      end
    end
  end

  assign RESULT = result_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed-vector bench for alu_seq_muldiv: issue-time scoreboard push, output monitor pops and compares.
module tb_alu_seq_muldiv;

  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, KILL;
  logic [4:0]  SELECT;
  logic [31:0] DATA1, DATA2;
  logic        IN_READY, OUT_VALID, ZERO, BUSY;
  logic [31:0] RESULT;

  alu_seq_muldiv #(.WIDTH(32), .SEL_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SELECT(SELECT), .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL),
    .OUT_VALID(OUT_VALID), .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] exp_res;
  int          exp_lat;
  bit          exp_push = 1'b0;
  bit          xfer_seen = 1'b0;
  logic [31:0] last_res;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each output pulse with the oldest expectation, then record new transfers.
  always @(negedge CLK) begin
    exp_t e;
    if (OUT_VALID === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got RESULT %h with no operation pending (t=%0t)", RESULT, $time);
      end else begin
        e = q.pop_front();
        chk("result", RESULT, e.res);
        chk("zero", {31'b0, ZERO}, {31'b0, (e.res == 32'd0)});
        chk("latency_cycle", cyc, e.at);
      end
    end
    if (RESET === 1'b1 && KILL === 1'b0 && IN_VALID === 1'b1 && IN_READY === 1'b1) begin
      xfer_seen = 1'b1;
      if (exp_push) begin
        e.res = exp_res;
        e.at  = cyc + exp_lat;
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input bit push);
    SELECT = sel; DATA1 = a; DATA2 = b;
    exp_res = r; exp_lat = lat; exp_push = push;
    xfer_seen = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (xfer_seen) break;
    end
    if (!xfer_seen) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: op %h never accepted", sel);
    end
    IN_VALID = 1'b0;
    exp_push = 1'b0;
    if (push) last_res = r;
  endtask

  task automatic busy_check(input string name);
    int nb = 0;
    int nr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (OUT_VALID === 1'b1) break;
      if (BUSY === 1'b1) nb++;
      if (IN_READY !== 1'b1) nr++;
    end
    chk({name, "_busy_cycles"}, nb, 32);
    chk({name, "_not_ready_cycles"}, nr, 32);
    @(posedge CLK); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge CLK);
    repeat (2) @(posedge CLK);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
      q.delete();
    end
  endtask

  initial begin
    RESET = 1'b0; KILL = 1'b0; IN_VALID = 1'b1;
    SELECT = 5'h02; DATA1 = 32'd1; DATA2 = 32'd1;
    last_res = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_result", RESULT, 32'd0);
    chk("reset_zero", {31'b0, ZERO}, 32'd1);
    chk("reset_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("reset_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("reset_busy", {31'b0, BUSY}, 32'd0);
    IN_VALID = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Basic ops, back-to-back
    issue(5'h02, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1);
    issue(5'h06, 32'd5,         32'd5,         32'h0000_0000, 1, 1);
    issue(5'h07, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, 1);
    issue(5'h08, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 1);
    issue(5'h09, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 1);
    issue(5'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, 1);
    issue(5'h01, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1, 1);
    issue(5'h03, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1, 1);
    issue(5'h04, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1, 1);
    issue(5'h05, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1, 1);
    drain();

    // Multiply
    issue(5'h10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 1);
    busy_check("mul");
    issue(5'h11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1);
    busy_check("mulh");
    issue(5'h13, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 33, 1);
    busy_check("mulhu");
    issue(5'h12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1);
    drain();

    // Divide, including back-to-back issue from DONE
    issue(5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1);
    issue(5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1);
    issue(5'h15, 32'd100,       32'd7, 32'd14,        33, 1);
    issue(5'h17, 32'd100,       32'd7, 32'd2,         33, 1);
    issue(5'h14, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, 1);
    issue(5'h16, 32'd20, 32'hFFFF_FFFD, 32'd2,         33, 1);
    drain();
    issue(5'h14, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1);
    issue(5'h15, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1);
    issue(5'h16, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 1);
    issue(5'h17, 32'h0000_5678, 32'd0, 32'h0000_5678, 1, 1);
    issue(5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    issue(5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
    issue(5'h02, 32'd40, 32'd2, 32'd42, 1, 1);
    drain();

    // KILL mid-divide: no output, RESULT keeps its last value
    issue(5'h15, 32'd100, 32'd7, 32'd14, 33, 0);
    repeat (9) @(posedge CLK);
    #1 KILL = 1'b1;
    @(posedge CLK); #1;
    KILL = 1'b0;
    chk("kill_in_ready", {31'b0, IN_READY}, 32'd1);
    chk("kill_busy", {31'b0, BUSY}, 32'd0);
    chk("kill_result_held", RESULT, last_res);
    repeat (40) @(posedge CLK);
    #1;

    // Reset mid-divide: RESULT cleared, no output
    issue(5'h15, 32'd100, 32'd7, 32'd14, 33, 0);
    repeat (9) @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    last_res = 32'd0;
    chk("midreset_result", RESULT, 32'd0);
    chk("midreset_zero", {31'b0, ZERO}, 32'd1);
    chk("midreset_in_ready", {31'b0, IN_READY}, 32'd1);
    repeat (40) @(posedge CLK);
    #1;

    // KILL coincident with a transfer drops the op
    SELECT = 5'h02; DATA1 = 32'd2; DATA2 = 32'd3;
    IN_VALID = 1'b1; KILL = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; KILL = 1'b0;
    chk("kill_xfer_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("kill_xfer_result", RESULT, last_res);
    repeat (3) @(posedge CLK);
    #1;

    // Unknown opcode
    issue(5'h1F, 32'd5, 32'd6, 32'd0, 1, 1);
    issue(5'h02, 32'd1, 32'd2, 32'd3, 1, 1);
    drain();

    // Operand changes during MUL are ignored
    issue(5'h10, 32'd3, 32'd5, 32'd15, 33, 1);
    SELECT = 5'h14; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'h1234_5678;
    repeat (5) @(posedge CLK);
    #1 DATA1 = 32'h0000_0007; DATA2 = 32'h0000_0009;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
